// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-requester ALU arbiter
package alu_arb_pkg;
    localparam int ALU_WIDTH = 4;
    localparam int ALU_OPW   = 4;
    localparam int STAT_W    = 8;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [ALU_OPW-1:0] OP_ADD  = 4'h0;
    localparam logic [ALU_OPW-1:0] OP_ADC  = 4'h1;
    localparam logic [ALU_OPW-1:0] OP_SUB  = 4'h2;
    localparam logic [ALU_OPW-1:0] OP_SBC  = 4'h3;
    localparam logic [ALU_OPW-1:0] OP_AND  = 4'h4;
    localparam logic [ALU_OPW-1:0] OP_OR   = 4'h5;
    localparam logic [ALU_OPW-1:0] OP_XOR  = 4'h6;
    localparam logic [ALU_OPW-1:0] OP_NAND = 4'h7;
    localparam logic [ALU_OPW-1:0] OP_NOR  = 4'h8;
    localparam logic [ALU_OPW-1:0] OP_XNOR = 4'h9;
    localparam logic [ALU_OPW-1:0] OP_NOTA = 4'hA;
    localparam logic [ALU_OPW-1:0] OP_NOTB = 4'hB;
    localparam logic [ALU_OPW-1:0] OP_INC  = 4'hC;
    localparam logic [ALU_OPW-1:0] OP_DEC  = 4'hD;
    localparam logic [ALU_OPW-1:0] OP_PASA = 4'hE;
    localparam logic [ALU_OPW-1:0] OP_PASB = 4'hF;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant
// ports: req_valid (pending requests), last_grant (previous winner), grant (one-hot, 0 if none)
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    assign grant = &req_valid ? (last_grant ? 2'b01 : 2'b10) : req_valid;
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one combinational ALU between two requesters, round-robin
// ports: req_* (request handshake, packed per requester), rsp_* (response handshake + captured result),
//        alu_* (registered opcode/operands out, combinational result in)
// optional: ALU_ARB_STATS_EN adds saturating per-requester accept counters grant_cnt0/grant_cnt1
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*OPW-1:0]   req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_s,
    output logic               rsp_cout,
    output logic [OPW-1:0]     alu_sel,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_s,
    input  logic               alu_cout
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]  grant_cnt0,
    output logic [STAT_W-1:0]  grant_cnt1
`endif
);
    state_t     state, state_nx;
    logic [2:0] cnt;
    logic       owner, last_grant, gi, accept, done;
    logic [1:0] grant;
    if (LAT < 1 || LAT > 7) begin : g_lat_chk
        $error("alu_req_arbiter: LAT must be in 1..7");
    end
    rr_arb2 u_rr (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .grant     (grant)
    );
    assign gi        = grant[1];
    // gated by rst so nothing is offered while reset is held
    assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign done      = cnt == 3'(LAT - 1);
    assign rsp_valid = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
    always_comb begin
        state_nx = (state == IDLE && accept)           ? EXEC :
                   (state == EXEC && done)             ? RESP :
                   (state == RESP && rsp_ready[owner]) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_s      <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                alu_sel    <= gi ? req_op[OPW +: OPW]     : req_op[0 +: OPW];
                alu_a      <= gi ? req_a[WIDTH +: WIDTH]  : req_a[0 +: WIDTH];
                alu_b      <= gi ? req_b[WIDTH +: WIDTH]  : req_b[0 +: WIDTH];
                owner      <= gi;
                last_grant <= gi;
                cnt        <= '0;
            end
            if (state == EXEC) begin
                cnt <= cnt + 3'd1;
                if (done) {rsp_cout, rsp_s} <= {alu_cout, alu_s};
            end
        end
    end
`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!gi && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (gi && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed table plus corner sequences for alu_req_arbiter
module tb_alu_req_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [7:0] req_op = '0, req_a = '0, req_b = '0;
    logic [3:0] rsp_s, alu_sel, alu_a, alu_b, alu_s;
    logic       rsp_cout, alu_cout;
    logic [1:0] req3_valid = '0, req3_ready, rsp3_valid, rsp3_ready = '0;
    logic [7:0] req3_op = '0, req3_a = '0, req3_b = '0;
    logic [3:0] rsp3_s, alu3_sel, alu3_a, alu3_b, alu3_s = '0;
    logic       rsp3_cout;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1, g3_cnt0, g3_cnt1;
`endif
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    assign {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
    alu_req_arbiter #(.WIDTH(4), .OPW(4), .LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s),
        .rsp_cout(rsp_cout), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_cout(alu_cout)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );
    alu_req_arbiter #(.WIDTH(4), .OPW(4), .LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req3_valid), .req_ready(req3_ready), .req_op(req3_op),
        .req_a(req3_a), .req_b(req3_b), .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_s(rsp3_s),
        .rsp_cout(rsp3_cout), .alu_sel(alu3_sel), .alu_a(alu3_a), .alu_b(alu3_b), .alu_s(alu3_s),
        .alu_cout(1'b0)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(g3_cnt0), .grant_cnt1(g3_cnt1)
`endif
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    typedef struct {
        logic [1:0] v;
        logic [3:0] op, a0, b0, a1, b1;
        logic [1:0] g;
        logic [3:0] s;
        logic       c;
    } vec_t;
    vec_t tbl[8];
    initial begin
        tbl[0] = '{2'b01, 4'h5, 4'hA, 4'h5, 4'h1, 4'h1, 2'b01, 4'hF, 1'b0};
        tbl[1] = '{2'b11, 4'h1, 4'h1, 4'h1, 4'h9, 4'h8, 2'b10, 4'h1, 1'b1};
        tbl[2] = '{2'b11, 4'h2, 4'h7, 4'h7, 4'h2, 4'h3, 2'b01, 4'hE, 1'b0};
        tbl[3] = '{2'b11, 4'h3, 4'h5, 4'h5, 4'hF, 4'h1, 2'b10, 4'h0, 1'b1};
        tbl[4] = '{2'b11, 4'h4, 4'h3, 4'h4, 4'h6, 4'h6, 2'b01, 4'h7, 1'b0};
        tbl[5] = '{2'b10, 4'h6, 4'hC, 4'hC, 4'h0, 4'h0, 2'b10, 4'h0, 1'b0};
        tbl[6] = '{2'b10, 4'h7, 4'h9, 4'h9, 4'h2, 4'h2, 2'b10, 4'h4, 1'b0};
        tbl[7] = '{2'b11, 4'h8, 4'h8, 4'h8, 4'h1, 4'h2, 2'b01, 4'h0, 1'b1};
        req_valid = 2'b11;
        #2;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_alu", {alu_sel, alu_a, alu_b}, 12'h000);
        chk("rst_rsp", {rsp_cout, rsp_s}, 5'h00);
        req_valid = 2'b00;
        tick;
        tick;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].v;
            req_op = {tbl[i].op, tbl[i].op};
            req_a = {tbl[i].a1, tbl[i].a0};
            req_b = {tbl[i].b1, tbl[i].b0};
            rsp_ready = 2'b00;
            #1;
            chk($sformatf("v%0d_grant", i), req_ready, tbl[i].g);
            tick;
            chk($sformatf("v%0d_alu_sel", i), alu_sel, tbl[i].op);
            chk($sformatf("v%0d_alu_a", i), alu_a, tbl[i].g[1] ? tbl[i].a1 : tbl[i].a0);
            chk($sformatf("v%0d_alu_b", i), alu_b, tbl[i].g[1] ? tbl[i].b1 : tbl[i].b0);
            chk($sformatf("v%0d_exec_idle", i), {req_ready, rsp_valid}, 4'h0);
            tick;
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tbl[i].g);
            chk($sformatf("v%0d_rsp", i), {rsp_cout, rsp_s}, {tbl[i].c, tbl[i].s});
            chk($sformatf("v%0d_resp_ready", i), req_ready, 2'b00);
            rsp_ready = tbl[i].g;
            tick;
            chk($sformatf("v%0d_rsp_done", i), rsp_valid, 2'b00);
        end
        req_valid = 2'b11;
        req_a = 8'h62;
        req_b = 8'h32;
        rsp_ready = 2'b00;
        #1;
        chk("stall_grant", req_ready, 2'b10);
        tick;
        tick;
        rsp_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_valid", k), rsp_valid, 2'b10);
            chk($sformatf("stall%0d_rsp", k), {rsp_cout, rsp_s}, 5'h09);
            chk($sformatf("stall%0d_ready", k), req_ready, 2'b00);
            tick;
        end
        rsp_ready = 2'b10;
        #1;
        chk("stall_hs_valid", rsp_valid, 2'b10);
        chk("stall_hs_ready", req_ready, 2'b00);
        tick;
        chk("stall_post_valid", rsp_valid, 2'b00);
        chk("stall_post_grant", req_ready, 2'b01);
        rsp_ready = 2'b00;
        req_a = 8'h12;
        req_b = 8'h12;
        tick;
        rst = 1'b1;
        #1;
        chk("mid_rst_alu", {alu_sel, alu_a, alu_b}, 12'h000);
        chk("mid_rst_rsp", {rsp_valid, rsp_cout, rsp_s}, 7'h00);
        chk("mid_rst_ready", req_ready, 2'b00);
        tick;
        tick;
        chk("mid_rst_no_rsp", rsp_valid, 2'b00);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        tick;
        chk("post_rst_idle", rsp_valid, 2'b00);
        req3_valid = 2'b10;
        req3_op = 8'h30;
        req3_a = 8'h40;
        req3_b = 8'h40;
        #1;
        chk("lat3_grant", req3_ready, 2'b10);
        tick;
        req3_valid = 2'b00;
        alu3_s = 4'h1;
        chk("lat3_t1_valid", rsp3_valid, 2'b00);
        tick;
        alu3_s = 4'h2;
        tick;
        alu3_s = 4'h3;
        chk("lat3_t3_valid", rsp3_valid, 2'b00);
        tick;
        alu3_s = 4'h9;
        chk("lat3_t4_valid", rsp3_valid, 2'b10);
        chk("lat3_rsp_s", rsp3_s, 4'h3);
        rsp3_ready = 2'b10;
        tick;
        chk("lat3_done", rsp3_valid, 2'b00);
        chk("lat3_hold", rsp3_s, 4'h3);
`ifdef ALU_ARB_STATS_EN
        begin
            int acc = 0;
            chk("stats_init", {grant_cnt0, grant_cnt1}, 16'h0000);
            req_valid = 2'b01;
            rsp_ready = 2'b11;
            for (int k = 0; k < 2000 && acc < 300; k++) begin
                if (req_ready[0]) acc++;
                tick;
            end
            req_valid = 2'b00;
            chk("stats_accepts", acc, 300);
            chk("stats_cnt0", grant_cnt0, 8'd255);
            chk("stats_cnt1", grant_cnt1, 8'd0);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
